dm_arbiter: RTL

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the data-memory port between the CPU M-stage and a DMA
// master. CPU normally wins; a starvation counter hands one slot to a waiting
// DMA after STARVE_MAX consecutive CPU grants. DMA completion is signalled by
// a one-cycle ack with the read data registered at the grant edge.
module dm_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  input  logic [3:0]  cpu_be,
  input  logic        cpu_kill,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wd,
  input  logic [3:0]  dma_be,
  output logic        dma_ack,
  output logic [31:0] dma_rd,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [3:0]  dm_be,
  output logic        dm_we,
  input  logic [31:0] dm_rd
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        last_was_dma_q, last_was_dma_d;
  logic        dma_ack_q, dma_ack_d;
  logic [31:0] dma_rd_q, dma_rd_d;
  logic        cpu_grant, dma_grant;

  // Grant decision: CPU wins unless DMA has waited STARVE_MAX CPU grants and
  // the previous slot did not already go to DMA.
  always_comb begin
    cpu_grant = cpu_req & (~dma_req | (starve_cnt_q < STARVE_LIM) | last_was_dma_q);
    dma_grant = dma_req & ~cpu_grant;
  end

  // Memory port mux; killed CPU accesses keep their slot but never write.
  always_comb begin
    dm_addr   = '0;
    dm_wd     = '0;
    dm_be     = '0;
    dm_we     = 1'b0;
    cpu_stall = cpu_req & ~cpu_grant;
    if (cpu_grant) begin
      dm_addr = cpu_addr;
      dm_wd   = cpu_wd;
      dm_be   = cpu_be;
      dm_we   = cpu_we & ~cpu_kill;
    end else if (dma_grant) begin
      dm_addr = dma_addr;
      dm_wd   = dma_wd;
      dm_be   = dma_be;
      dm_we   = dma_we;
    end
  end

  // Next-state for starvation tracking and DMA completion; reset wins over a
  // grant so an in-flight DMA ack is dropped.
  always_comb begin
    starve_cnt_d   = starve_cnt_q;
    last_was_dma_d = last_was_dma_q;
    dma_ack_d      = dma_grant;
    dma_rd_d       = dma_rd_q;
    if (dma_grant || !dma_req) begin
      starve_cnt_d = '0;
    end else if (cpu_grant && (starve_cnt_q < STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
    if (dma_grant) begin
      last_was_dma_d = 1'b1;
      dma_rd_d       = dm_rd;
    end else if (cpu_grant) begin
      last_was_dma_d = 1'b0;
    end
    if (Reset) begin
      starve_cnt_d   = '0;
      last_was_dma_d = 1'b0;
      dma_ack_d      = 1'b0;
      dma_rd_d       = '0;
    end
  end

  // State registers.
  always_ff @(posedge Clk) begin
    starve_cnt_q   <= starve_cnt_d;
    last_was_dma_q <= last_was_dma_d;
    dma_ack_q      <= dma_ack_d;
    dma_rd_q       <= dma_rd_d;
  end

  assign dma_ack = dma_ack_q;
  assign dma_rd  = dma_rd_q;

endmodule
